instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch / decode / dispatch to ALU, load-store and branch FSMs, then retire.
// Optional watchdog on EXEC enabled by defining SEQ_WATCHDOG_EN.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imemReq,
    input  logic        imemAck,
    input  logic [15:0] imemData,
    output logic [15:0] ir,
    output logic        aluStart,
    input  logic        aluDone,
    output logic        memStart,
    input  logic        memDone,
    output logic        brStart,
    input  logic        brDone,
    input  logic        brTaken,
    output logic        pcInc,
    output logic        pcLoad,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_RETIRE,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] ir_reg;
    logic        br_taken_reg;

    logic is_alu;
    logic is_mem;
    logic is_br;
    logic is_nop;
    logic is_halt;
    logic unit_done;
    logic wd_expired;

    // ir is held between fetches, so class decode stays valid through EXEC and RETIRE.
    always_comb begin
        is_alu  = ir_reg[15];
        is_mem  = (ir_reg[15:14] == 2'b01);
        is_br   = (ir_reg[15:13] == 3'b001);
        is_nop  = (ir_reg == 16'h0000);
        is_halt = (ir_reg[15:12] == 4'b0001);
    end

    assign unit_done = (is_alu & aluDone) | (is_mem & memDone) | (is_br & brDone);

`ifdef SEQ_WATCHDOG_EN
    logic [5:0] wd_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_count_reg <= 6'd0;
        end else if (state_reg == S_DECODE) begin
            wd_count_reg <= 6'd0;
        end else if (state_reg == S_EXEC && !unit_done) begin
            wd_count_reg <= wd_count_reg + 6'd1;
        end
    end

    // Count equals (EXEC cycle index - 1): 63 means this is the 64th EXEC cycle.
    assign wd_expired = (wd_count_reg == 6'd63);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            ir_reg       <= 16'h0000;
            br_taken_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH && imemAck) begin
                ir_reg <= imemData;
            end
            if (state_reg == S_EXEC && is_br && brDone) begin
                br_taken_reg <= brTaken;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imemAck) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu || is_mem || is_br) state_next = S_EXEC;
                else if (is_nop)               state_next = S_RETIRE;
                else if (is_halt)              state_next = S_HALT;
                else                           state_next = S_FAULT;
            end
            S_EXEC: begin
                if (unit_done)       state_next = S_RETIRE;
                else if (wd_expired) state_next = S_FAULT;
            end
            S_RETIRE: begin
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_next = S_HALT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imemReq  = 1'b0;
        aluStart = 1'b0;
        memStart = 1'b0;
        brStart  = 1'b0;
        pcInc    = 1'b0;
        pcLoad   = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        unique case (state_reg)
            S_FETCH:  imemReq = 1'b1;
            S_DECODE: begin
                aluStart = is_alu;
                memStart = is_mem;
                brStart  = is_br;
            end
            S_RETIRE: begin
                pcLoad = is_br & br_taken_reg;
                pcInc  = ~(is_br & br_taken_reg);
            end
            S_HALT:   halted = 1'b1;
            S_FAULT:  fault  = 1'b1;
            default:  ;
        endcase
    end

    assign ir = ir_reg;

endmodule
